// File: rtl/uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx : oversampling UART receiver, 2-flop rx synchronizer, optional
//           parity, valid/ready hand-off with frame/parity/overrun flags.
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] C_TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] C_TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          C_ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;
    logic                   done;
    logic                   xfer;
    logic                   rx_s;

    assign rx_s = sync2_q;
    assign xfer = rx_valid_q & rx_ready;

    // Receive FSM: every transition is gated by baud_tick.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done    = 1'b0;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == C_TICK_MID) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_q == C_TICK_END) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == C_LAST_BIT) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                PARITY: begin
                    if (tick_q == C_TICK_END) begin
                        tick_d  = '0;
                        par_d   = rx_s ^ (^shift_q) ^ C_ODD;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_q == C_TICK_END) begin
                        tick_d  = '0;
                        done    = 1'b1;
                        state_d = rx_s ? IDLE : WAIT_HIGH;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A completing frame wins over a same-cycle transfer and suppresses overrun.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        if (done) begin
            rx_data_d    = shift_q;
            rx_valid_d   = 1'b1;
            frame_err_d  = ~rx_s;
            parity_err_d = (PARITY_EN != 0) ? par_q : 1'b0;
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else if (xfer) begin
                overrun_d = 1'b0;
            end
        end else if (xfer) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= rx;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_q;
    assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx : directed frames into an 8N1 and an 8E1 receiver.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int C_BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [1:0] r_div = 2'd0;

    logic [7:0] rx_data, rxp_data;
    logic       rx_valid, frame_err, parity_err, overrun_err, busy;
    logic       rxp_valid, rxp_frame_err, rxp_parity_err, rxp_overrun_err, rxp_busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .parity_err(parity_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dutp (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx(rx),
        .rx_data(rxp_data), .rx_valid(rxp_valid), .rx_ready(rx_ready),
        .frame_err(rxp_frame_err), .parity_err(rxp_parity_err),
        .overrun_err(rxp_overrun_err), .busy(rxp_busy)
    );

    always #5 clk = ~clk;

    // One baud_tick every 4 clk.
    always @(posedge clk) begin
        r_div     <= r_div + 2'd1;
        baud_tick <= (r_div == 2'd3);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic line(input logic v, input int clks);
        rx = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par_bit,
                              input logic stop_v, input int stop_periods);
        line(1'b0, C_BIT_CLKS);
        for (int i = 0; i < 8; i++) line(d[i], C_BIT_CLKS);
        if (par_en) line(par_bit, C_BIT_CLKS);
        line(stop_v, C_BIT_CLKS * stop_periods);
        if (stop_v) line(1'b1, C_BIT_CLKS);
    endtask

    task automatic take();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] d77;
        d77 = 8'h77;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(rx_data), 32'h00);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_ovr", 32'(overrun_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        line(1'b1, C_BIT_CLKS);
        chk("idle_busy", 32'(busy), 32'd0);

        // Clean 8N1 frame 0xA5
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_valid", 32'(rx_valid), 32'd1);
        chk("a5_ferr", 32'(frame_err), 32'd0);
        chk("a5_perr", 32'(parity_err), 32'd0);
        chk("a5_ovr", 32'(overrun_err), 32'd0);
        chk("a5_busy", 32'(busy), 32'd0);
        take();
        chk("a5_take", 32'(rx_valid), 32'd0);

        // Start-bit glitch: 4 ticks low
        line(1'b0, 16);
        chk("gl_busy_hi", 32'(busy), 32'd1);
        line(1'b1, C_BIT_CLKS);
        chk("gl_busy_lo", 32'(busy), 32'd0);
        chk("gl_valid", 32'(rx_valid), 32'd0);

        // Stop bit held low for 3 bit periods
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 3);
        chk("fe_valid", 32'(rx_valid), 32'd1);
        chk("fe_ferr", 32'(frame_err), 32'd1);
        chk("fe_data", 32'(rx_data), 32'h3C);
        chk("fe_wait", 32'(busy), 32'd1);
        line(1'b1, C_BIT_CLKS);
        chk("fe_idle", 32'(busy), 32'd0);
        chk("fe_stable", 32'(rx_data), 32'h3C);
        chk("fe_ovr", 32'(overrun_err), 32'd0);
        take();
        chk("fe_take", 32'(rx_valid), 32'd0);

        // Overrun: two frames without a transfer
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1);
        chk("ov1_data", 32'(rx_data), 32'h11);
        chk("ov1_ovr", 32'(overrun_err), 32'd0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1);
        chk("ov2_data", 32'(rx_data), 32'h22);
        chk("ov2_valid", 32'(rx_valid), 32'd1);
        chk("ov2_ovr", 32'(overrun_err), 32'd1);
        take();
        chk("ov_take_v", 32'(rx_valid), 32'd0);
        chk("ov_take_o", 32'(overrun_err), 32'd0);

        // Reset during data bit 4
        line(1'b0, C_BIT_CLKS);
        for (int i = 0; i < 4; i++) line(d77[i], C_BIT_CLKS);
        line(d77[4], C_BIT_CLKS / 2);
        chk("mr_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("mr_rst_busy", 32'(busy), 32'd0);
        chk("mr_rst_valid", 32'(rx_valid), 32'd0);
        reset_n = 1'b1;
        line(1'b1, 2 * C_BIT_CLKS);
        chk("mr_valid", 32'(rx_valid), 32'd0);
        chk("mr_busy_lo", 32'(busy), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1);
        chk("mr_5a_data", 32'(rx_data), 32'h5A);
        chk("mr_5a_valid", 32'(rx_valid), 32'd1);
        chk("mr_5a_ferr", 32'(frame_err), 32'd0);

        // Even parity receiver
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        line(1'b1, C_BIT_CLKS);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1);
        chk("p1_valid", 32'(rxp_valid), 32'd1);
        chk("p1_data", 32'(rxp_data), 32'h03);
        chk("p1_perr", 32'(rxp_parity_err), 32'd1);
        chk("p1_ferr", 32'(rxp_frame_err), 32'd0);
        take();
        chk("p1_take", 32'(rxp_valid), 32'd0);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1);
        chk("p0_valid", 32'(rxp_valid), 32'd1);
        chk("p0_perr", 32'(rxp_parity_err), 32'd0);
        chk("p0_ovr", 32'(rxp_overrun_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning number of data bits per frame; legal range 5-8.
REQ-002 Parameter OVERSAMPLE, default 16, meaning baud_tick pulses per bit period; even value, minimum 8.
REQ-003 Parameter PARITY_EN, default 0, meaning 1 = one parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 Port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-006 Port reset_n, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-007 Port baud_tick, input, 1 bit, meaning one-clk pulse at OVERSAMPLE x baud rate, from the baud generator.
REQ-008 Port rx, input, 1 bit, meaning asynchronous serial line; idles high.
REQ-009 Port rx_data, output, DATA_BITS bits, meaning the last received data word, LSB first on the line.
REQ-010 Port rx_valid, output, 1 bit, meaning rx_data holds an unread word.
REQ-011 Port rx_ready, input, 1 bit, meaning the consumer accepts rx_data; a transfer occurs on any clk where rx_valid and rx_ready are both 1.
REQ-012 Port frame_err, output, 1 bit, meaning the stop bit of the word in rx_data was sampled low.
REQ-013 Port parity_err, output, 1 bit, meaning the parity check of the word in rx_data failed.
REQ-014 Port overrun_err, output, 1 bit, meaning a word was lost because rx_valid was still 1.
REQ-015 Port busy, output, 1 bit, meaning the FSM is not in IDLE.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer; every function below uses the synchronized value only.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-018 In IDLE, a low synchronized rx SHALL move the FSM to START and clear the tick counter.
REQ-019 The tick counter SHALL advance only on baud_tick; clk cycles without baud_tick SHALL hold all state.
REQ-020 In START, on tick count OVERSAMPLE/2-1:
- rx low: go to DATA and restart the tick counter.
- rx high: treat as a glitch and return to IDLE with no output change.
REQ-021 In DATA, each bit SHALL be sampled at tick count OVERSAMPLE-1, i.e. mid-bit, and shifted in LSB first.
REQ-022 After DATA_BITS data bits, the FSM SHALL go to PARITY when PARITY_EN=1, else to STOP.
REQ-023 In PARITY, the sampled bit XOR the data-bit XOR XOR PARITY_ODD SHALL give the parity error, where 1 = error.
REQ-024 In STOP, at the mid-bit sample the block SHALL, in one clk:
- load rx_data;
- set rx_valid=1;
- set frame_err = ~rx;
- set parity_err to the PARITY result, or 0 when PARITY_EN=0.
REQ-025 The next state from STOP SHALL be IDLE when the stop bit is high, and WAIT_HIGH when it is low.
REQ-026 WAIT_HIGH SHALL return to IDLE only when synchronized rx is high, so that a break never starts a false frame.
REQ-027 The frame SHALL end at mid-stop-bit; rx_valid SHALL rise 1 clk after the baud_tick that samples the stop bit.
REQ-028 rx_valid SHALL stay 1 until a transfer; rx_data, frame_err and parity_err SHALL stay stable while rx_valid=1.
REQ-029 A transfer SHALL clear rx_valid on the next clk.
REQ-030 If a new frame completes while rx_valid=1 and no transfer occurs in that clk:
- rx_data and the error flags are overwritten with the new frame;
- rx_valid stays 1;
- overrun_err is set to 1.
REQ-031 If a transfer and a frame completion occur in the same clk, the new word SHALL load, rx_valid SHALL stay 1, and overrun_err SHALL NOT be set.
REQ-032 overrun_err SHALL be sticky and SHALL clear on the next transfer, unless REQ-030 sets it again in that same clk.
REQ-033 busy SHALL be 1 in every state except IDLE.

Reset
REQ-034 While reset_n=0, regardless of clk:
- FSM = IDLE, counters = 0;
- both synchronizer flops = 1;
- rx_data = 0 and rx_valid, frame_err, parity_err, overrun_err, busy = 0.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame and produce no rx_valid.
REQ-036 After reset_n deasserts, reception SHALL begin only on a new falling edge of rx seen from IDLE.

Verification
REQ-037 8N1 line driving 0xA5, baud_tick every 4 clk -> rx_data=0xA5, rx_valid=1, all error flags 0, busy returns to 0.
REQ-038 rx low for 4 ticks, then high -> no rx_valid, FSM back in IDLE, busy=0 within 1 clk of the OVERSAMPLE/2-1 sample.
REQ-039 Frame 0x3C with stop bit held low for 3 bit periods -> rx_valid=1, frame_err=1, rx_data=0x3C; no second frame starts before rx returns high.
REQ-040 PARITY_EN=1, PARITY_ODD=0, data 0x03 with parity bit 1 -> parity_err=1; same frame with parity bit 0 -> parity_err=0.
REQ-041 Frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x22 and overrun_err=1; one clk of rx_ready=1 -> rx_valid=0 and overrun_err=0.
REQ-042 reset_n pulsed low during data bit 4 of a frame, then a clean 0x5A frame -> no output for the first frame; rx_data=0x5A with rx_valid=1 for the second.
